// File: rtl/coherent_bus_arbiter_pkg.sv
// Shared types for the coherent bus arbiter: RAM handshake, bus FSM states and
// request kinds, plus the mapping from a granted request to its first state.
package coherent_bus_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    IFETCH,
    WB,
    SNOOP,
    C2C,
    MEMRD,
    INV
  } bus_state_t;

  typedef enum logic [2:0] {
    KindIfetch,
    KindMemRd,
    KindWb,
    KindSnoop,
    KindInv
  } bus_kind_t;

  // A coherence read snoops first; a bare coherence transaction is an upgrade.
  function automatic bus_kind_t dcache_kind(input logic ren, input logic wen, input logic trans);
    bus_kind_t kind;
    if (ren && trans) begin
      kind = KindSnoop;
    end else if (ren) begin
      kind = KindMemRd;
    end else if (wen) begin
      kind = KindWb;
    end else begin
      kind = KindInv;
    end
    return kind;
  endfunction

  function automatic bus_state_t kind_state(input bus_kind_t kind);
    bus_state_t st;
    unique case (kind)
      KindIfetch: st = IFETCH;
      KindMemRd:  st = MEMRD;
      KindWb:     st = WB;
      KindSnoop:  st = SNOOP;
      KindInv:    st = INV;
      default:    st = IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/coherent_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
module coherent_bus_arbiter_rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  always_comb begin
    int unsigned pos;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (32'(ptr_i) + i) % N;
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && (j == pos) && req_i[j]) begin
          found    = 1'b1;
          gnt_o[j] = 1'b1;
          idx_o    = IdxW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/coherent_bus_arbiter.sv
// Snooping bus controller: NCORES icache/dcache pairs share one RAM port, with
// round-robin fairness, dcache priority and cache-to-cache dirty block transfer.
module coherent_bus_arbiter
  import coherent_bus_arbiter_pkg::*;
#(
  parameter int unsigned NCORES    = 2,
  parameter int unsigned BLK_WORDS = 2,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NCORES-1:0]              iREN,
  input  logic [NCORES-1:0][ADDR_W-1:0]  iaddr,
  output logic [NCORES-1:0]              iwait,
  output word_t [NCORES-1:0]             iload,
  input  logic [NCORES-1:0]              dREN,
  input  logic [NCORES-1:0]              dWEN,
  input  logic [NCORES-1:0][ADDR_W-1:0]  daddr,
  input  word_t [NCORES-1:0]             dstore,
  output logic [NCORES-1:0]              dwait,
  output word_t [NCORES-1:0]             dload,
  input  logic [NCORES-1:0]              cctrans,
  input  logic [NCORES-1:0]              ccwrite,
  output logic [NCORES-1:0]              ccwait,
  output logic [NCORES-1:0]              ccinv,
  output logic [NCORES-1:0][ADDR_W-1:0]  ccsnoopaddr,
  output logic [ADDR_W-1:0]              ramaddr,
  output word_t                          ramstore,
  output logic                           ramREN,
  output logic                           ramWEN,
  input  word_t                          ramload,
  input  ramstate_t                      ramstate
);

  localparam int unsigned IdxW  = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int unsigned WcntW = $clog2(BLK_WORDS) + 1;

  bus_state_t       state_q, state_d;
  logic [IdxW-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]  sup_q, sup_d;
  logic [IdxW-1:0]  rr_q, rr_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;

  logic [NCORES-1:0] d_req, d_gnt, i_gnt;
  logic [IdxW-1:0]   d_idx, i_idx;
  logic              acc, last, xfer_req, done, found;

  assign d_req = dREN | dWEN | cctrans;
  assign acc   = (ramstate == ACCESS);
  assign last  = (wcnt_q == WcntW'(BLK_WORDS - 1));
  // Write-back is kept alive by dWEN; every read-type transfer by dREN.
  assign xfer_req = (state_q == WB) ? dWEN[grant_q] : dREN[grant_q];

  coherent_bus_arbiter_rr_arbiter #(
    .N(NCORES)
  ) u_d_arb (
    .req_i(d_req),
    .ptr_i(rr_q),
    .gnt_o(d_gnt),
    .idx_o(d_idx)
  );

  coherent_bus_arbiter_rr_arbiter #(
    .N(NCORES)
  ) u_i_arb (
    .req_i(iREN),
    .ptr_i(rr_q),
    .gnt_o(i_gnt),
    .idx_o(i_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sup_d   = sup_q;
    rr_d    = rr_q;
    wcnt_d  = wcnt_q;
    done    = 1'b0;
    found   = 1'b0;
    unique case (state_q)
      IDLE: begin
        wcnt_d = '0;
        if (|d_gnt) begin
          grant_d = d_idx;
          state_d = kind_state(dcache_kind(dREN[d_idx], dWEN[d_idx], cctrans[d_idx]));
        end else if (|i_gnt) begin
          grant_d = i_idx;
          state_d = kind_state(KindIfetch);
        end
      end
      IFETCH: done = !iREN[grant_q] || acc;
      WB, C2C, MEMRD: begin
        if (!xfer_req) begin
          done = 1'b1;
        end else if (acc) begin
          done   = last;
          wcnt_d = wcnt_q + WcntW'(1);
        end
      end
      SNOOP: begin
        // Lowest-indexed dirty hit supplies the block.
        for (int unsigned k = 0; k < NCORES; k++) begin
          if (!found && ccwrite[k] && (IdxW'(k) != grant_q)) begin
            found = 1'b1;
            sup_d = IdxW'(k);
          end
        end
        state_d = found ? C2C : MEMRD;
      end
      INV: done = 1'b1;
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d = IDLE;
      wcnt_d  = '0;
      rr_d    = (grant_q == IdxW'(NCORES - 1)) ? '0 : grant_q + IdxW'(1);
    end
  end

  always_comb begin
    iwait       = '1;
    dwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramaddr     = '0;
    ramstore    = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    iload       = {NCORES{ramload}};
    dload       = {NCORES{ramload}};
    unique case (state_q)
      IFETCH: begin
        if (iREN[grant_q]) begin
          ramREN  = 1'b1;
          ramaddr = iaddr[grant_q];
          iwait[grant_q] = !acc;
        end
      end
      WB: begin
        if (dWEN[grant_q]) begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[grant_q];
          ramstore = dstore[grant_q];
          dwait[grant_q] = !acc;
        end
      end
      SNOOP, INV: begin
        for (int unsigned k = 0; k < NCORES; k++) begin
          if (IdxW'(k) != grant_q) begin
            ccwait[k]      = 1'b1;
            ccsnoopaddr[k] = daddr[grant_q];
            ccinv[k]       = ccwrite[grant_q];
          end
        end
        if (state_q == INV) begin
          dwait[grant_q] = 1'b0;
        end
      end
      C2C: begin
        ccwait[sup_q]      = 1'b1;
        ccsnoopaddr[sup_q] = daddr[grant_q];
        dload[grant_q]     = dstore[sup_q];
        if (dREN[grant_q]) begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[sup_q];
          ramstore = dstore[sup_q];
          dwait[grant_q] = !acc;
          dwait[sup_q]   = !acc;
        end
      end
      MEMRD: begin
        if (dREN[grant_q]) begin
          ramREN  = 1'b1;
          ramaddr = daddr[grant_q];
          dwait[grant_q] = !acc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      sup_q   <= '0;
      rr_q    <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sup_q   <= sup_d;
      rr_q    <= rr_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_coherent_bus_arbiter.sv
// Directed bench for coherent_bus_arbiter with four cores and two-word blocks.
module tb_coherent_bus_arbiter;
  import coherent_bus_arbiter_pkg::*;

  logic              CLK, RST;
  logic [3:0]        iREN, dREN, dWEN, cctrans, ccwrite;
  logic [3:0]        iwait, dwait, ccwait, ccinv;
  logic [3:0][31:0]  iaddr, daddr, ccsnoopaddr;
  word_t [3:0]       iload, dload, dstore;
  logic [31:0]       ramaddr;
  word_t             ramstore, ramload;
  logic              ramREN, ramWEN;
  ramstate_t         ramstate;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  coherent_bus_arbiter #(
    .NCORES(4),
    .BLK_WORDS(2),
    .ADDR_W(32)
  ) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    n_checks++;
    if ({iwait, dwait, ccwait, ccinv, ramREN, ramWEN} !== {4'hF, 4'hF, 4'h0, 4'h0, 2'b00})
      $display("FAIL %s waits: got iw=%b dw=%b ccw=%b cci=%b ren=%b wen=%b expected F F 0 0 0 0",
               tag, iwait, dwait, ccwait, ccinv, ramREN, ramWEN);
    else n_pass++;
    n_checks++;
    if ({ramaddr, ramstore, ccsnoopaddr} !== 192'h0)
      $display("FAIL %s addr/data: got ramaddr=%h ramstore=%h snoop=%h expected all zero",
               tag, ramaddr, ramstore, ccsnoopaddr);
    else n_pass++;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cyc();
    cyc();
    check_idle_outputs("reset");
    RST = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_w;
    for (int k = 0; k < 4; k++) iaddr[k] = 32'h1000 + 32'(4 * k);
    ramload  = 32'h0000_0013;
    ramstate = ACCESS;
    iREN     = 4'hF;
    for (int n = 0; n < 5; n++) begin
      cyc();
      exp_w = 4'hF;
      exp_w[n % 4] = 1'b0;
      n_checks++;
      if ({iwait, ramREN, ramWEN} !== {exp_w, 2'b10})
        $display("FAIL rr_grant%0d: got iwait=%b ren=%b wen=%b expected iwait=%b ren=1 wen=0",
                 n, iwait, ramREN, ramWEN, exp_w);
      else n_pass++;
      n_checks++;
      if (ramaddr !== 32'(32'h1000 + 4 * (n % 4)) || iload[n % 4] !== 32'h13)
        $display("FAIL rr_addr%0d: got ramaddr=%h iload=%h expected %h 00000013",
                 n, ramaddr, iload[n % 4], 32'(32'h1000 + 4 * (n % 4)));
      else n_pass++;
      cyc();
    end
    iREN = 4'h0;
  endtask

  task automatic test_dcache_priority();
    dREN[1]  = 1'b1;
    daddr[1] = 32'h100;
    iREN[0]  = 1'b1;
    iaddr[0] = 32'h200;
    ramload  = 32'h1111;
    cyc();
    n_checks++;
    if ({dwait, iwait, ramREN, ramaddr, dload[1]} !== {4'b1101, 4'hF, 1'b1, 32'h100, 32'h1111})
      $display("FAIL prio_word0: got dw=%b iw=%b ren=%b addr=%h dload1=%h expected 1101 1111 1 100 1111",
               dwait, iwait, ramREN, ramaddr, dload[1]);
    else n_pass++;
    ramload = 32'h2222;
    cyc();
    n_checks++;
    if ({dwait, iwait, dload[1]} !== {4'b1101, 4'hF, 32'h2222})
      $display("FAIL prio_word1: got dw=%b iw=%b dload1=%h expected 1101 1111 2222",
               dwait, iwait, dload[1]);
    else n_pass++;
    cyc();
    dREN[1] = 1'b0;
    #1;
    check_idle_outputs("prio_idle");
    cyc();
    n_checks++;
    if ({iwait, ramREN, ramaddr} !== {4'b1110, 1'b1, 32'h200})
      $display("FAIL prio_ifetch: got iw=%b ren=%b addr=%h expected 1110 1 200", iwait, ramREN, ramaddr);
    else n_pass++;
    cyc();
    iREN = 4'h0;
  endtask

  task automatic setup_c2c();
    dREN[0]    = 1'b1;
    cctrans[0] = 1'b1;
    daddr[0]   = 32'h40;
    daddr[1]   = 32'h40;
    ccwrite[1] = 1'b1;
    dstore[1]  = 32'hDEAD;
    ramstate   = ACCESS;
  endtask

  task automatic test_c2c();
    setup_c2c();
    cyc();
    n_checks++;
    if ({ccwait, ccinv, ccsnoopaddr[1], ramREN, ramWEN, dwait} !== {4'b1110, 4'h0, 32'h40, 2'b00, 4'hF})
      $display("FAIL c2c_snoop: got ccw=%b cci=%b snp1=%h ren=%b wen=%b dw=%b expected 1110 0000 40 0 0 1111",
               ccwait, ccinv, ccsnoopaddr[1], ramREN, ramWEN, dwait);
    else n_pass++;
    cyc();
    n_checks++;
    if ({ramREN, ramWEN, ramaddr, ramstore, dload[0], dwait, ccwait} !==
        {2'b01, 32'h40, 32'hDEAD, 32'hDEAD, 4'b1100, 4'b0010})
      $display("FAIL c2c_word0: got ren=%b wen=%b addr=%h st=%h dl0=%h dw=%b ccw=%b expected 0 1 40 dead dead 1100 0010",
               ramREN, ramWEN, ramaddr, ramstore, dload[0], dwait, ccwait);
    else n_pass++;
    daddr[0]  = 32'h44;
    daddr[1]  = 32'h44;
    dstore[1] = 32'hBEEF;
    cyc();
    n_checks++;
    if ({ramREN, ramWEN, ramaddr, ramstore, dload[0], dwait} !==
        {2'b01, 32'h44, 32'hBEEF, 32'hBEEF, 4'b1100})
      $display("FAIL c2c_word1: got ren=%b wen=%b addr=%h st=%h dl0=%h dw=%b expected 0 1 44 beef beef 1100",
               ramREN, ramWEN, ramaddr, ramstore, dload[0], dwait);
    else n_pass++;
    cyc();
    dREN[0] = 1'b0; cctrans[0] = 1'b0; ccwrite[1] = 1'b0;
    #1;
    check_idle_outputs("c2c_done");
  endtask

  task automatic test_inv();
    cctrans[0] = 1'b1;
    ccwrite[0] = 1'b1;
    daddr[0]   = 32'h80;
    cyc();
    n_checks++;
    if ({ccinv, ccwait, ccsnoopaddr[1], dwait, ramREN, ramWEN} !== {4'b1110, 4'b1110, 32'h80, 4'b1110, 2'b00})
      $display("FAIL inv: got cci=%b ccw=%b snp1=%h dw=%b ren=%b wen=%b expected 1110 1110 80 1110 0 0",
               ccinv, ccwait, ccsnoopaddr[1], dwait, ramREN, ramWEN);
    else n_pass++;
    cyc();
    cctrans[0] = 1'b0; ccwrite[0] = 1'b0;
    #1;
    check_idle_outputs("inv_done");
  endtask

  task automatic test_memrd_error();
    dREN[0]    = 1'b1;
    cctrans[0] = 1'b1;
    daddr[0]   = 32'hC0;
    ramstate   = ERROR;
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({dwait, ramREN, ramWEN, ramaddr} !== {4'hF, 2'b10, 32'hC0})
        $display("FAIL memrd_err%0d: got dw=%b ren=%b wen=%b addr=%h expected 1111 1 0 c0",
                 i, dwait, ramREN, ramWEN, ramaddr);
      else n_pass++;
      cyc();
    end
    ramstate = ACCESS;
    ramload  = 32'h5555;
    #1;
    n_checks++;
    if ({dwait, dload[0], ramaddr} !== {4'b1110, 32'h5555, 32'hC0})
      $display("FAIL memrd_acc0: got dw=%b dl0=%h addr=%h expected 1110 5555 c0", dwait, dload[0], ramaddr);
    else n_pass++;
    cyc();
    ramload = 32'h6666;
    #1;
    n_checks++;
    if ({dwait, dload[0]} !== {4'b1110, 32'h6666})
      $display("FAIL memrd_acc1: got dw=%b dl0=%h expected 1110 6666", dwait, dload[0]);
    else n_pass++;
    cyc();
    dREN[0] = 1'b0; cctrans[0] = 1'b0; ramstate = FREE;
    #1;
    check_idle_outputs("memrd_done");
  endtask

  task automatic test_wb_abort();
    dWEN[2]   = 1'b1;
    daddr[2]  = 32'h500;
    dstore[2] = 32'hA5A5;
    ramstate  = BUSY;
    cyc();
    n_checks++;
    if ({ramREN, ramWEN, ramaddr, ramstore, dwait} !== {2'b01, 32'h500, 32'hA5A5, 4'hF})
      $display("FAIL wb_busy: got ren=%b wen=%b addr=%h st=%h dw=%b expected 0 1 500 a5a5 1111",
               ramREN, ramWEN, ramaddr, ramstore, dwait);
    else n_pass++;
    ramstate = ACCESS;
    #1;
    n_checks++;
    if (dwait !== 4'b1011)
      $display("FAIL wb_access: got dw=%b expected 1011", dwait);
    else n_pass++;
    cyc();
    dWEN[2] = 1'b0;
    #1;
    n_checks++;
    if ({ramREN, ramWEN, dwait} !== {2'b00, 4'hF})
      $display("FAIL wb_abort: got ren=%b wen=%b dw=%b expected 0 0 1111", ramREN, ramWEN, dwait);
    else n_pass++;
    cyc();
  endtask

  task automatic test_reset_mid_c2c();
    setup_c2c();
    cyc();
    cyc();
    cyc();
    ramstate = BUSY;
    RST      = 1'b1;
    #1;
    n_checks++;
    if ({ramWEN, dwait} !== {1'b1, 4'hF})
      $display("FAIL midc2c_busy: got wen=%b dw=%b expected 1 1111", ramWEN, dwait);
    else n_pass++;
    cyc();
    RST = 1'b0;
    dREN[0] = 1'b0; cctrans[0] = 1'b0; ccwrite[1] = 1'b0;
    iREN     = 4'b0011;
    iaddr[0] = 32'h300;
    iaddr[1] = 32'h304;
    ramstate = ACCESS;
    #1;
    check_idle_outputs("midc2c_reset");
    cyc();
    n_checks++;
    if ({iwait, ramaddr} !== {4'b1110, 32'h300})
      $display("FAIL midc2c_rrptr: got iw=%b addr=%h expected 1110 300", iwait, ramaddr);
    else n_pass++;
    cyc();
    iREN = 4'h0;
  endtask

  initial begin
    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    test_reset();
    test_round_robin();
    test_dcache_priority();
    test_c2c();
    test_inv();
    test_memrd_error();
    test_wb_abort();
    test_reset_mid_c2c();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
